// File: rtl/fifo_stream_reader.sv
// Stream adapter between a synchronous FIFO with 1-cycle registered read data
// and a valid/ready consumer, buffering up to two words to keep full throughput.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  m_valid_q, m_valid_d;
  logic                  pop, push;
  logic [1:0]            committed;

  always_comb begin
    pop = m_valid_q & m_ready;
    // Slots already spoken for once this cycle's pop leaves; never exceeds 2.
    committed  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    fifo_rd_en = !rst && !flush && !fifo_empty && (committed < 2'd2);
    // A word arriving during a flush belongs to the discarded stream.
    push = inflight_q & !flush;

    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = fifo_rd_en;

    if (flush) begin
      occ_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_d = fifo_rd_data;
          else               tail_d = fifo_rd_data;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_d = tail_q;
            tail_d = fifo_rd_data;
          end else begin
            head_d = fifo_rd_data;
          end
        end
        default: ;
      endcase
    end

    m_valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign m_data    = head_q;
  assign m_valid   = m_valid_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: cycle vectors for the directed cases, then a
// randomized run against a queue-based FIFO model and an in-order scoreboard.
module tb_fifo_stream_reader;

  logic       clk;
  logic       rst;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       fifo_empty;
  logic       flush;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [1:0] occupancy;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_clr;
  logic [7:0] fifo_mem[$];

  int n_checks;
  int n_pass;

  fifo_stream_reader #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .flush       (flush),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: registered read data, registered empty flag.
  initial fifo_empty = 1'b1;
  initial fifo_rd_data = 8'h00;
  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_mem.delete();
    end else begin
      if (fifo_rd_en && fifo_mem.size() > 0) fifo_rd_data <= fifo_mem.pop_front();
      if (wr_en) fifo_mem.push_back(wr_data);
    end
    fifo_empty <= (fifo_mem.size() == 0);
  end

  typedef struct {
    logic       rst;
    logic       flush;
    logic       rdy;
    logic       wr;
    logic [7:0] wd;
    logic       e_rd;
    logic       e_valid;
    logic [7:0] e_data;
    logic       chk_data;
    logic [1:0] e_occ;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic fl, input logic rdy,
                              input logic wr, input logic [7:0] wd,
                              input logic e_rd, input logic e_valid,
                              input logic [7:0] e_data, input logic chk_data,
                              input logic [1:0] e_occ);
    vec_t v;
    v.rst = r; v.flush = fl; v.rdy = rdy; v.wr = wr; v.wd = wd;
    v.e_rd = e_rd; v.e_valid = e_valid; v.e_data = e_data;
    v.chk_data = chk_data; v.e_occ = e_occ;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input bit ok, input string msg);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, msg);
  endtask

  // Drive inputs just after the falling edge, let combinational outputs settle.
  task automatic step(input logic r, input logic fl, input logic rdy,
                      input logic wr, input logic [7:0] wd);
    @(negedge clk);
    rst = r; flush = fl; m_ready = rdy; wr_en = wr; wr_data = wd;
    #1;
  endtask

  task automatic preload8();
    for (int i = 0; i < 8; i++) add(0, 1, 0, 1, 8'(i), 0, 0, 8'h00, 0, 2'd0);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] next_word;
  int         words_written;
  int         rx;
  logic       prev_valid, prev_ready;
  logic [7:0] prev_data;
  bit         ok;

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    fifo_clr = 1'b0;

    // Reset held with a word entering the FIFO, then a single word at m_ready=1
    add(1, 0, 0, 1, 8'hAA, 0, 0, 8'h00, 1, 2'd0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2'd0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2'd0);
    add(0, 0, 1, 0, 8'h00, 1, 0, 8'h00, 1, 2'd0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 2'd0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 8'hAA, 1, 2'd1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 2'd0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 2'd0);

    // Streaming: word k is read in cycle k and presented in cycle k+2
    preload8();
    for (int k = 0; k <= 10; k++)
      add(0, 0, 1, 0, 8'h00, (k < 8), (k >= 2 && k <= 9), 8'(k - 2),
          (k >= 2 && k <= 9), (k >= 2 && k <= 9) ? 2'd1 : 2'd0);

    // Backpressure: two reads fill the buffer, then release drains in order
    preload8();
    for (int b = 0; b < 6; b++)
      add(0, 0, 0, 0, 8'h00, (b < 2), (b >= 2), 8'h00, (b >= 2),
          (b < 2) ? 2'd0 : ((b == 2) ? 2'd1 : 2'd2));
    add(0, 0, 1, 0, 8'h00, 1, 1, 8'h00, 1, 2'd2);
    for (int r = 1; r <= 7; r++)
      add(0, 0, 1, 0, 8'h00, (r <= 5), 1, 8'(r), 1, 2'd1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 2'd0);

    // Flush with a word in flight, then flush coinciding with a pop
    preload8();
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd0);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 8'h00, 1, 2'd1);
    add(0, 0, 0, 0, 8'h00, 0, 1, 8'h00, 1, 2'd2);
    add(0, 0, 1, 0, 8'h00, 1, 1, 8'h00, 1, 2'd2);
    add(0, 1, 0, 0, 8'h00, 0, 1, 8'h01, 1, 2'd1);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd0);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 8'h03, 1, 2'd1);
    add(0, 1, 1, 0, 8'h00, 0, 1, 8'h03, 1, 2'd2);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd0);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 8'h05, 1, 2'd1);
    add(0, 0, 0, 0, 8'h00, 0, 1, 8'h05, 1, 2'd2);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].rdy, tbl[i].wr, tbl[i].wd);
      ok = (fifo_rd_en === tbl[i].e_rd) && (m_valid === tbl[i].e_valid) &&
           (occupancy === tbl[i].e_occ) &&
           (!tbl[i].chk_data || (m_data === tbl[i].e_data));
      $display("row %0d: rd_en=%0b valid=%0b data=%02h occ=%0d", i,
               fifo_rd_en, m_valid, m_data, occupancy);
      chk($sformatf("row%0d", i), ok,
          $sformatf("rd_en=%0b want %0b, valid=%0b want %0b, data=%02h want %02h, occ=%0d want %0d",
                    fifo_rd_en, tbl[i].e_rd, m_valid, tbl[i].e_valid,
                    m_data, tbl[i].e_data, occupancy, tbl[i].e_occ));
    end

    // Reset mid-operation with the FIFO cleared alongside
    fifo_clr = 1'b1;
    step(1, 0, 0, 0, 8'h00);
    chk("midrst_rd_en", fifo_rd_en === 1'b0,
        $sformatf("rd_en=%0b want 0", fifo_rd_en));
    fifo_clr = 1'b0;
    step(0, 0, 0, 0, 8'h00);
    $display("after reset: rd_en=%0b valid=%0b data=%02h occ=%0d",
             fifo_rd_en, m_valid, m_data, occupancy);
    chk("midrst_state",
        (m_valid === 1'b0) && (occupancy === 2'd0) && (m_data === 8'h00) && (fifo_rd_en === 1'b0),
        $sformatf("valid=%0b occ=%0d data=%02h rd_en=%0b want 0/0/00/0",
                  m_valid, occupancy, m_data, fifo_rd_en));

    // Random traffic: scoreboard holds words in write order
    next_word = 8'h00; words_written = 0; rx = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00;
    for (int cyc = 0; cyc < 6000 && rx < 256; cyc++) begin
      logic wr;
      logic rdy;
      wr  = (words_written < 256) && ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 9) < 3);
      step(0, 0, rdy, wr, next_word);
      if (wr) begin
        exp_q.push_back(next_word);
        next_word = next_word + 8'd1;
        words_written++;
      end
      chk("occ_bound", occupancy <= 2'd2 && (m_valid === (occupancy != 2'd0)),
          $sformatf("occ=%0d valid=%0b at cycle %0d", occupancy, m_valid, cyc));
      chk("rd_on_empty", !(fifo_rd_en && fifo_empty),
          $sformatf("rd_en=%0b while empty=%0b at cycle %0d", fifo_rd_en, fifo_empty, cyc));
      if (prev_valid && !prev_ready)
        chk("stall_stable", (m_valid === 1'b1) && (m_data === prev_data),
            $sformatf("valid=%0b data=%02h want 1/%02h at cycle %0d",
                      m_valid, m_data, prev_data, cyc));
      if (m_valid && m_ready) begin
        logic [7:0] want;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        $display("pop %0d: data=%02h", rx, m_data);
        chk("order", m_data === want,
            $sformatf("word %0d data=%02h want %02h", rx, m_data, want));
        rx++;
      end
      prev_valid = m_valid; prev_ready = m_ready; prev_data = m_data;
    end
    chk("rand_complete", rx == 256 && exp_q.size() == 0,
        $sformatf("received %0d want 256, %0d left in scoreboard", rx, exp_q.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
